// File: rtl/sqrt_sequencer.sv
// Initiator for the square-root core's start/done handshake: pops operand pairs,
// runs the core, pushes results, and recovers a hung core by pulsing its clear.
module sqrt_sequencer #(
   parameter int W       = 5,
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   input  logic [2*W-1:0]   fifo_dout,
   output logic [W-1:0]     sq_in1,
   output logic [W-1:0]     sq_in2,
   output logic             sq_start,
   output logic             sq_clear,
   input  logic             sq_done,
   input  logic [W-1:0]     sq_out,
   input  logic             res_full,
   output logic             res_wr,
   output logic [W-1:0]     res_din,
   output logic             busy,
   output logic             err_timeout,
   output logic [CNT_W-1:0] res_count
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_START,
      S_WAIT,
      S_RECOVER,
      S_PUSH
   } state_t;

   state_t           state_q, state_d;
   logic             fifo_rd_q, fifo_rd_d;
   logic             sq_start_q, sq_start_d;
   logic             sq_clear_q, sq_clear_d;
   logic             res_wr_q, res_wr_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [W-1:0]     in1_q, in1_d;
   logic [W-1:0]     in2_q, in2_d;
   logic [W-1:0]     res_din_q, res_din_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]    timer_q, timer_d;

   always_comb begin
      state_d    = state_q;
      fifo_rd_d  = 1'b0;
      sq_start_d = 1'b0;
      sq_clear_d = 1'b1;
      res_wr_d   = 1'b0;
      err_d      = err_q;
      in1_d      = in1_q;
      in2_d      = in2_q;
      res_din_d  = res_din_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_d = 1'b1;
               state_d   = S_POP;
            end
         end
         S_POP: begin
            in1_d      = fifo_dout[2*W-1:W];
            in2_d      = fifo_dout[W-1:0];
            sq_start_d = 1'b1;
            state_d    = S_START;
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done takes priority over an expiry in the same cycle
            if (sq_done) begin
               res_din_d = sq_out;
               state_d   = S_PUSH;
            end else if (timer_q == TMAX) begin
               err_d      = 1'b1;
               sq_clear_d = 1'b0;
               state_d    = S_RECOVER;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RECOVER: begin
            state_d = S_IDLE;
         end
         S_PUSH: begin
            if (!res_full) begin
               res_wr_d = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         state_q    <= S_IDLE;
         fifo_rd_q  <= 1'b0;
         sq_start_q <= 1'b0;
         sq_clear_q <= 1'b1;
         res_wr_q   <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         in1_q      <= '0;
         in2_q      <= '0;
         res_din_q  <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         fifo_rd_q  <= fifo_rd_d;
         sq_start_q <= sq_start_d;
         sq_clear_q <= sq_clear_d;
         res_wr_q   <= res_wr_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         in1_q      <= in1_d;
         in2_q      <= in2_d;
         res_din_q  <= res_din_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
      end
   end

   assign fifo_rd     = fifo_rd_q;
   assign sq_start    = sq_start_q;
   assign sq_clear    = sq_clear_q;
   assign res_wr      = res_wr_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;
   assign sq_in1      = in1_q;
   assign sq_in2      = in2_q;
   assign res_din     = res_din_q;
   assign res_count   = cnt_q;

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Scoreboard bench for sqrt_sequencer: FWFT input FIFO, latency-programmable
// core model, result queue checked by an independent monitor.
module tb_sqrt_sequencer;

   localparam int W  = 5;
   localparam int TO = 32;
   localparam int CW = 8;
   localparam int HANG = 1000;

   logic          clk = 1'b0;
   logic          clear;
   logic          fifo_empty;
   logic          fifo_rd;
   logic [2*W-1:0] fifo_dout;
   logic [W-1:0]  sq_in1, sq_in2, sq_out, res_din;
   logic          sq_start, sq_clear, sq_done;
   logic          res_full, res_wr, busy, err_timeout;
   logic [CW-1:0] res_count;

   always #5 clk = ~clk;

   sqrt_sequencer #(.W(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .clear(clear),
      .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
      .sq_in1(sq_in1), .sq_in2(sq_in2), .sq_start(sq_start),
      .sq_clear(sq_clear), .sq_done(sq_done), .sq_out(sq_out),
      .res_full(res_full), .res_wr(res_wr), .res_din(res_din),
      .busy(busy), .err_timeout(err_timeout), .res_count(res_count)
   );

   typedef struct {
      int a;
      int b;
      int lat;
   } op_t;

   int checks = 0;
   int failures = 0;

   logic [2*W-1:0] pend_q[$];
   logic [2*W-1:0] fq[$];
   op_t run_q[$];
   int  exp_q[$];

   int n_ops = 0, n_to_exp = 0;
   int n_rd = 0, n_start = 0, n_clr = 0, n_push = 0;
   int cyc = 0, start_cyc = 0, cur_lat = 0, ccnt = 0;
   bit bp_en = 0;
   bit rf_force = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Reference: integer square root of the sum of squares, W-bit result
   function automatic int ref_sqrt(input int a, input int b);
      int s, r;
      s = a * a + b * b;
      r = 0;
      while ((r + 1) * (r + 1) <= s) r++;
      return r & ((1 << W) - 1);
   endfunction

   task automatic push_op(input int a, input int b, input int lat);
      op_t o;
      logic [W-1:0] av, bv;
      o.a = a; o.b = b; o.lat = lat;
      av = W'(a); bv = W'(b);
      pend_q.push_back({av, bv});
      run_q.push_back(o);
      n_ops++;
      if (lat <= TO - 1) exp_q.push_back(ref_sqrt(a, b));
      else n_to_exp++;
   endtask

   task automatic wait_drain(input int budget);
      int left;
      left = budget;
      do begin
         @(negedge clk); #1;
         left--;
      end while (left > 0 && (pend_q.size() + fq.size() + run_q.size()
                 + exp_q.size() != 0 || busy));
      if (left == 0)
         chk("drain_timeout", pend_q.size() + fq.size() + run_q.size()
             + exp_q.size() + 32'(busy), 0);
   endtask

   // First-word-fall-through input FIFO
   always @(posedge clk) begin : fifo_model
      logic p;
      p = fifo_rd;
      #1;
      if (p === 1'b1 && fq.size() > 0) void'(fq.pop_front());
      while (pend_q.size() > 0) fq.push_back(pend_q.pop_front());
      fifo_empty = (fq.size() == 0);
      fifo_dout = (fq.size() == 0) ? '0 : fq[0];
   end

   // Core: done comes cur_lat cycles after start, cleared by sq_clear
   always @(posedge clk) begin : core_model
      logic st, cl;
      st = sq_start;
      cl = sq_clear;
      #1;
      if (cl === 1'b0) begin
         ccnt = 0;
         sq_done = 1'b0;
      end else if (st === 1'b1) begin
         ccnt = cur_lat;
         sq_done = (cur_lat == 0);
         sq_out = (cur_lat == 0) ? W'(ref_sqrt(int'(sq_in1), int'(sq_in2)))
                                 : W'($urandom_range(0, 31));
      end else if (ccnt > 1) begin
         ccnt--;
      end else if (ccnt == 1) begin
         ccnt = 0;
         sq_done = 1'b1;
         sq_out = W'(ref_sqrt(int'(sq_in1), int'(sq_in2)));
      end
   end

   always @(negedge clk) begin
      res_full = bp_en ? ($urandom_range(0, 3) == 0) : rf_force;
   end

   always @(negedge clk) begin : monitor
      op_t o;
      cyc++;
      if (clear === 1'b1) begin
         if (fifo_rd) n_rd++;
         if (sq_start) begin
            n_start++;
            start_cyc = cyc;
            if (run_q.size() > 0) begin
               o = run_q.pop_front();
               chk("sq_in1", 32'(sq_in1), o.a);
               chk("sq_in2", 32'(sq_in2), o.b);
               cur_lat = o.lat;
            end else begin
               chk("start_unexpected", run_q.size(), 1);
            end
         end
         if (!sq_clear) begin
            n_clr++;
            chk("timeout_cycles", cyc - start_cyc, TO + 1);
         end
         if (res_wr) begin
            n_push++;
            if (exp_q.size() > 0) chk("res_din", 32'(res_din), exp_q.pop_front());
            else chk("res_wr_unexpected", exp_q.size(), 1);
            chk("res_count", 32'(res_count), n_push % (1 << CW));
         end
      end
   end

   initial begin
      int k, a0, b0;
      clear = 1'b0;
      sq_done = 1'b0;
      sq_out = '0;
      // reset with a pending operand (also the single-op case)
      push_op(3, 4, 3);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_fifo_empty_seen", 32'(fifo_empty), 0);
      chk("rst_fifo_rd", 32'(fifo_rd), 0);
      chk("rst_sq_start", 32'(sq_start), 0);
      chk("rst_res_wr", 32'(res_wr), 0);
      chk("rst_sq_clear", 32'(sq_clear), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(res_count), 0);
      chk("rst_err", 32'(err_timeout), 0);
      clear = 1'b1;
      wait_drain(200);
      chk("single_res_din", 32'(res_din), 5);
      chk("single_count", 32'(res_count), 1);
      chk("single_rd", n_rd, 1);
      chk("single_start", n_start, 1);

      // back-pressure held at PUSH
      rf_force = 1'b1;
      push_op(6, 8, 3);
      repeat (25) @(negedge clk);
      #1;
      chk("bp_no_wr", n_push, 1);
      chk("bp_din_held", 32'(res_din), 10);
      chk("bp_busy", 32'(busy), 1);
      rf_force = 1'b0;
      wait_drain(200);
      chk("bp_one_wr", n_push, 2);

      // done on the last WAIT cycle and one cycle earlier
      push_op(5, 12, TO - 1);
      push_op(8, 15, TO - 2);
      wait_drain(400);
      chk("race_pushes", n_push, 4);
      chk("race_no_err", 32'(err_timeout), 0);
      chk("race_no_clr", n_clr, 0);

      // timeouts, then a normal op with the flag still set
      push_op(1, 1, TO);
      push_op(2, 3, HANG);
      push_op(7, 24, 2);
      wait_drain(600);
      chk("to_err", 32'(err_timeout), 1);
      chk("to_clr", n_clr, 2);
      chk("to_pushes", n_push, 5);

      // randomized stream with back-pressure, wraps the counter
      bp_en = 1'b1;
      for (int i = 0; i < 257; i++) begin
         a0 = $urandom_range(0, 31);
         b0 = $urandom_range(0, 31);
         push_op(a0, b0, $urandom_range(0, 6));
      end
      wait_drain(20000);
      bp_en = 1'b0;
      chk("stream_pushes", n_push, 262);
      chk("stream_count", 32'(res_count), 262 % (1 << CW));
      chk("ops_rd", n_rd, n_ops);
      chk("ops_start", n_start, n_ops);
      chk("clr_pulses", n_clr, n_to_exp);
      chk("err_sticky", 32'(err_timeout), 1);

      // reset while the core is running
      pend_q.push_back({5'd9, 5'd9});
      run_q.push_back('{a: 9, b: 9, lat: HANG});
      k = n_start;
      for (int i = 0; i < 50 && n_start == k; i++) @(negedge clk);
      chk("rst_op_started", n_start, k + 1);
      repeat (3) @(negedge clk);
      clear = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_sq_clear", 32'(sq_clear), 1);
      chk("midrst_count", 32'(res_count), 0);
      chk("midrst_err", 32'(err_timeout), 0);
      clear = 1'b1;
      repeat (50) @(negedge clk);
      #1;
      chk("midrst_no_push", n_push, 262);
      chk("midrst_no_clr", n_clr, n_to_exp);
      chk("midrst_idle", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
